stopwatch_time_core: RTL

- MM:SS stopwatch timebase and mode controller, clocked by the ~500 Hz multiplex clock.
- Directly upstream of the seven-segment multiplexer. It drives the four BCD digits and the blank_min/blank_sec blink controls.
- Handles run/pause, clear, and an adjust mode in which the selected field blinks and is incremented by button.
- Button inputs are already debounced single-cycle pulses in the clk_mux domain.

---
 rtl/stopwatch_time_core.sv | 80 ++++++++
 1 files changed

// File: rtl/stopwatch_time_core.sv
// stopwatch_time_core: MM:SS stopwatch timebase with run/pause, clear and blinking field adjust
module stopwatch_time_core #(
    parameter int TICKS_PER_SEC = 500,
    parameter int BLINK_HALF    = 125
) (
    input  logic       clk_mux,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       btn_adj,
    input  logic       btn_inc,
    input  logic       sel,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running
);
    localparam int DW = $clog2(TICKS_PER_SEC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {STOP, RUN, ADJ} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic [3:0]    d3_n, d2_n, d1_n, d0_n;
    logic          do_pause, do_clr, do_inc, tick, sec_inc, min_inc, bclr, bwrap;

    // next-state, divider, digit and blink logic with button priority adj > pause > clr > inc
    always_comb begin
        do_pause = btn_pause & ~btn_adj & (state != ADJ);
        do_clr   = btn_clr & ~btn_adj & ~btn_pause & (state == STOP);
        do_inc   = btn_inc & ~btn_adj & (state == ADJ);
        tick     = (state == RUN) && (div == DW'(TICKS_PER_SEC - 1));
        sec_inc  = tick | (do_inc & sel);
        min_inc  = (tick & (digit1 == 4'd5) & (digit0 == 4'd9)) | (do_inc & ~sel);
        state_n  = btn_adj ? ((state == ADJ) ? STOP : ADJ)
                 : do_pause ? ((state == RUN) ? STOP : RUN) : state;
        div_n    = (btn_adj | do_clr) ? '0 : (state == RUN) ? (tick ? '0 : div + DW'(1)) : div;
        d0_n     = do_clr ? 4'd0 : sec_inc ? ((digit0 == 4'd9) ? 4'd0 : digit0 + 4'd1) : digit0;
        d1_n     = do_clr ? 4'd0 : (sec_inc && digit0 == 4'd9) ? ((digit1 == 4'd5) ? 4'd0 : digit1 + 4'd1) : digit1;
        d2_n     = do_clr ? 4'd0 : min_inc ? ((digit2 == 4'd9) ? 4'd0 : digit2 + 4'd1) : digit2;
        d3_n     = do_clr ? 4'd0 : (min_inc && digit2 == 4'd9) ? ((digit3 == 4'd9) ? 4'd0 : digit3 + 4'd1) : digit3;
        bclr     = btn_adj | (state != ADJ) | do_inc;
        bwrap    = bcnt == BW'(BLINK_HALF - 1);
        bcnt_n   = (bclr | bwrap) ? '0 : bcnt + BW'(1);
        phase_n  = bclr ? 1'b0 : phase ^ bwrap;
    end

    // state, divider, blink and digit registers with asynchronous reset
    always_ff @(posedge clk_mux or posedge rst) begin
        if (rst) begin
            state  <= STOP;
            div    <= '0;
            bcnt   <= '0;
            phase  <= 1'b0;
            digit3 <= 4'd0;
            digit2 <= 4'd0;
            digit1 <= 4'd0;
            digit0 <= 4'd0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            bcnt   <= bcnt_n;
            phase  <= phase_n;
            digit3 <= d3_n;
            digit2 <= d2_n;
            digit1 <= d1_n;
            digit0 <= d0_n;
        end
    end

    assign running   = state == RUN;
    assign blank_min = (state == ADJ) & phase & ~sel;
    assign blank_sec = (state == ADJ) & phase & sel;
endmodule
